// File: rtl/id_pool_manager.sv
// id_pool_manager: in-order instruction ID allocator with out-of-order completion,
// partial rollback flush, flush-all, occupancy count and per-ID metadata storage.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   alloc_req/_data     allocation request and metadata written with it
//   alloc_id            next ID to hand out (head pointer)
//   alloc_available     head ID is free and no flush is pending (comb)
//   alloc_granted       allocation accepted this cycle (comb)
//   complete_valid/_id  per-port completion strobes and IDs
//   flush_valid/_id     squash IDs flush_id .. head-1 and roll head back
//   flush_all           squash every ID, head unchanged
//   read_id/read_data   metadata read port (comb)
//   inflight_count      number of IDs in flight (registered)
//   retire_inc          completions accepted in the previous cycle (registered)
//   error               one-cycle pulse after an illegal completion (registered)
module id_pool_manager #(
    parameter int unsigned  MAX_IDS            = 8,
    parameter int unsigned  NUM_COMPLETE_PORTS = 4,
    parameter int unsigned  META_W             = 32,
    parameter int unsigned  CNT_W              = $clog2(NUM_COMPLETE_PORTS + 1),
    localparam int unsigned ID_W               = $clog2(MAX_IDS)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   alloc_req,
    input  logic [META_W-1:0]                      alloc_data,
    output logic [ID_W-1:0]                        alloc_id,
    output logic                                   alloc_available,
    output logic                                   alloc_granted,
    input  logic [NUM_COMPLETE_PORTS-1:0]          complete_valid,
    input  logic [NUM_COMPLETE_PORTS-1:0][ID_W-1:0] complete_id,
    input  logic                                   flush_valid,
    input  logic [ID_W-1:0]                        flush_id,
    input  logic                                   flush_all,
    input  logic [ID_W-1:0]                        read_id,
    output logic [META_W-1:0]                      read_data,
    output logic [ID_W:0]                          inflight_count,
    output logic [CNT_W-1:0]                       retire_inc,
    output logic                                   error
);

    localparam int unsigned OCC_W = ID_W + 1;

    logic [MAX_IDS-1:0] inflight_q;
    logic [MAX_IDS-1:0] inflight_d;
    logic [ID_W-1:0]    head_q;
    logic [ID_W-1:0]    head_d;
    logic [OCC_W-1:0]   count_q;
    logic [OCC_W-1:0]   count_d;
    logic [CNT_W-1:0]   retire_q;
    logic [CNT_W-1:0]   retire_d;
    logic               error_q;
    logic               error_d;
    logic [META_W-1:0]  meta_q [MAX_IDS];

    logic [ID_W-1:0]    flush_len;
    logic [ID_W-1:0]    rel;
    logic [MAX_IDS-1:0] squash_mask;
    logic [MAX_IDS-1:0] accept_mask;
    logic [OCC_W-1:0]   squash_cnt;
    logic [ID_W-1:0]    cid;

    assign alloc_available = ~inflight_q[head_q] & ~flush_valid & ~flush_all;
    assign alloc_granted   = alloc_req & alloc_available;
    assign alloc_id        = head_q;
    assign read_data       = meta_q[read_id];
    assign inflight_count  = count_q;
    assign retire_inc      = retire_q;
    assign error           = error_q;

    // Rollback length; zero when flush_id already equals head (no-op flush).
    assign flush_len = head_q - flush_id;

    // IDs cleared by this cycle's flush; modular distance from flush_id selects the range.
    always_comb begin
        squash_mask = '0;
        rel         = '0;
        for (int i = 0; i < MAX_IDS; i++) begin
            rel = ID_W'(i) - flush_id;
            if (flush_all) begin
                squash_mask[i] = 1'b1;
            end else if (flush_valid && (rel < flush_len)) begin
                squash_mask[i] = 1'b1;
            end
        end
    end

    // Completion arbitration: squashed IDs drop silently, free or duplicate IDs flag an error.
    always_comb begin
        accept_mask = '0;
        retire_d    = '0;
        error_d     = 1'b0;
        cid         = '0;
        for (int p = 0; p < NUM_COMPLETE_PORTS; p++) begin
            cid = complete_id[p];
            if (complete_valid[p] && !squash_mask[cid]) begin
                if (!inflight_q[cid] || accept_mask[cid]) begin
                    error_d = 1'b1;
                end else begin
                    accept_mask[cid] = 1'b1;
                    retire_d         = retire_d + CNT_W'(1);
                end
            end
        end
    end

    // Number of live IDs removed by the flush.
    always_comb begin
        squash_cnt = '0;
        for (int i = 0; i < MAX_IDS; i++) begin
            if (squash_mask[i] && inflight_q[i]) begin
                squash_cnt = squash_cnt + OCC_W'(1);
            end
        end
    end

    // Next in-flight set, head and occupancy.
    always_comb begin
        inflight_d = inflight_q & ~squash_mask & ~accept_mask;
        head_d     = head_q;
        if (flush_valid && !flush_all) begin
            head_d = flush_id;
        end else if (alloc_granted) begin
            inflight_d[head_q] = 1'b1;
            head_d             = head_q + ID_W'(1);
        end
        count_d = count_q + OCC_W'(alloc_granted) - OCC_W'(retire_d) - squash_cnt;
    end

    // Control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= '0;
            head_q     <= '0;
            count_q    <= '0;
            retire_q   <= '0;
            error_q    <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            head_q     <= head_d;
            count_q    <= count_d;
            retire_q   <= retire_d;
            error_q    <= error_d;
        end
    end

    // Metadata storage, written on grant; intentionally not reset.
    always_ff @(posedge clk) begin
        if (alloc_granted) begin
            meta_q[head_q] <= alloc_data;
        end
    end

    a_grant_free: assert property (@(posedge clk) disable iff (rst)
        alloc_granted |-> !inflight_q[head_q]);

    a_count_popcount: assert property (@(posedge clk) disable iff (rst)
        32'(count_q) == $countones(inflight_q));

endmodule

// File: tb/tb_id_pool_manager.sv
// Bench for id_pool_manager: directed scenarios with literal expectations plus a
// rule-level model compared against the DUT on every falling edge outside reset.
module tb_id_pool_manager;

    localparam int N  = 8;
    localparam int NP = 4;
    localparam int MW = 32;
    localparam int IW = 3;
    localparam int CW = 3;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   alloc_req;
    logic [MW-1:0]          alloc_data;
    logic [IW-1:0]          alloc_id;
    logic                   alloc_available;
    logic                   alloc_granted;
    logic [NP-1:0]          complete_valid;
    logic [NP-1:0][IW-1:0]  complete_id;
    logic                   flush_valid;
    logic [IW-1:0]          flush_id;
    logic                   flush_all;
    logic [IW-1:0]          read_id;
    logic [MW-1:0]          read_data;
    logic [IW:0]            inflight_count;
    logic [CW-1:0]          retire_inc;
    logic                   error;

    int checks = 0;
    int errors = 0;

    id_pool_manager #(
        .MAX_IDS(N),
        .NUM_COMPLETE_PORTS(NP),
        .META_W(MW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .alloc_req(alloc_req),
        .alloc_data(alloc_data),
        .alloc_id(alloc_id),
        .alloc_available(alloc_available),
        .alloc_granted(alloc_granted),
        .complete_valid(complete_valid),
        .complete_id(complete_id),
        .flush_valid(flush_valid),
        .flush_id(flush_id),
        .flush_all(flush_all),
        .read_id(read_id),
        .read_data(read_data),
        .inflight_count(inflight_count),
        .retire_inc(retire_inc),
        .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_inf [N];
    bit          m_mv  [N];
    logic [31:0] m_meta[N];
    int          m_head;
    int          m_retire;
    bit          m_err;

    function automatic bit in_flush_range(int x, int fid, int head);
        int len;
        len = (head - fid + N) % N;
        return ((x - fid + N) % N) < len;
    endfunction

    function automatic int m_count();
        int c;
        c = 0;
        for (int i = 0; i < N; i++) c += int'(m_inf[i]);
        return c;
    endfunction

    function automatic bit exp_avail();
        return !m_inf[m_head] && !flush_valid && !flush_all;
    endfunction

    always @(posedge clk or posedge rst) begin : model_upd
        bit squash [N];
        bit done   [N];
        int acc;
        bit err;
        bit grant;
        int id;
        if (rst) begin
            for (int i = 0; i < N; i++) m_inf[i] = 1'b0;
            m_head   = 0;
            m_retire = 0;
            m_err    = 1'b0;
        end else begin
            grant = alloc_req && exp_avail();
            for (int x = 0; x < N; x++) begin
                squash[x] = flush_all || (flush_valid && in_flush_range(x, int'(flush_id), m_head));
                done[x]   = 1'b0;
            end
            acc = 0;
            err = 1'b0;
            for (int p = 0; p < NP; p++) begin
                if (complete_valid[p]) begin
                    id = int'(complete_id[p]);
                    if (!squash[id]) begin
                        if (!m_inf[id] || done[id]) err = 1'b1;
                        else begin
                            done[id] = 1'b1;
                            acc++;
                        end
                    end
                end
            end
            for (int x = 0; x < N; x++) if (squash[x] || done[x]) m_inf[x] = 1'b0;
            if (grant) begin
                m_inf[m_head]  = 1'b1;
                m_meta[m_head] = alloc_data;
                m_mv[m_head]   = 1'b1;
                m_head         = (m_head + 1) % N;
            end else if (flush_valid && !flush_all) begin
                m_head = int'(flush_id);
            end
            m_retire = acc;
            m_err    = err;
        end
    end

    // Continuous comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_alloc_id", alloc_id, m_head);
            chk("m_avail", alloc_available, exp_avail());
            chk("m_granted", alloc_granted, alloc_req && exp_avail());
            chk("m_count", inflight_count, m_count());
            chk("m_retire", retire_inc, m_retire);
            chk("m_error", error, m_err);
            if (m_mv[int'(read_id)]) chk("m_read_data", read_data, m_meta[int'(read_id)]);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin
        alloc_req      = 1'b0;
        alloc_data     = '0;
        complete_valid = '0;
        complete_id    = '0;
        flush_valid    = 1'b0;
        flush_id       = '0;
        flush_all      = 1'b0;
        read_id        = 3'd5;
        for (int i = 0; i < N; i++) m_mv[i] = 1'b0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_alloc_id", alloc_id, 0);
        chk("rst_avail", alloc_available, 1);
        chk("rst_count", inflight_count, 0);
        chk("rst_retire", retire_inc, 0);
        chk("rst_error", error, 0);

        // Fill the pool.
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            alloc_req  = 1'b1;
            alloc_data = 32'h100 + 32'(i);
            @(negedge clk);
            chk("fill_alloc_id", alloc_id, 64'(i));
            chk("fill_granted", alloc_granted, 1);
        end
        next_cycle();
        alloc_req = 1'b0;
        @(negedge clk);
        chk("full_count", inflight_count, 8);
        chk("full_avail", alloc_available, 0);
        chk("full_read5", read_data, 32'h105);

        // Two completions on a full pool; head stalls on busy id 1.
        next_cycle();
        complete_valid = 4'b0011;
        complete_id[0] = 3'd3;
        complete_id[1] = 3'd0;
        next_cycle();
        complete_valid = '0;
        alloc_req      = 1'b1;
        alloc_data     = 32'h300;
        @(negedge clk);
        chk("cmp_retire", retire_inc, 2);
        chk("cmp_count", inflight_count, 6);
        chk("cmp_alloc_id", alloc_id, 0);
        chk("cmp_avail", alloc_available, 1);
        chk("cmp_granted", alloc_granted, 1);
        next_cycle();
        @(negedge clk);
        chk("stall_alloc_id", alloc_id, 1);
        chk("stall_avail", alloc_available, 0);
        chk("stall_granted", alloc_granted, 0);
        chk("stall_count", inflight_count, 7);

        // Empty the pool, then roll head back to 0 through a flush of a free id.
        next_cycle();
        alloc_req = 1'b0;
        flush_all = 1'b1;
        next_cycle();
        flush_all   = 1'b0;
        flush_valid = 1'b1;
        flush_id    = 3'd0;
        @(negedge clk);
        chk("fa_count", inflight_count, 0);
        chk("fa_head", alloc_id, 1);
        next_cycle();
        flush_valid = 1'b0;
        @(negedge clk);
        chk("fl0_head", alloc_id, 0);
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            alloc_req  = 1'b1;
            alloc_data = 32'h200 + 32'(i);
        end
        next_cycle();
        alloc_req = 1'b0;
        @(negedge clk);
        chk("six_head", alloc_id, 6);
        chk("six_count", inflight_count, 6);
        chk("six_read5", read_data, 32'h205);

        // Partial flush with a same-cycle completion inside the range and an alloc attempt.
        next_cycle();
        flush_valid    = 1'b1;
        flush_id       = 3'd2;
        complete_valid = 4'b0001;
        complete_id[0] = 3'd4;
        alloc_req      = 1'b1;
        @(negedge clk);
        chk("fl_granted", alloc_granted, 0);
        chk("fl_avail", alloc_available, 0);
        next_cycle();
        flush_valid    = 1'b0;
        complete_valid = '0;
        alloc_req      = 1'b0;
        @(negedge clk);
        chk("fl_head", alloc_id, 2);
        chk("fl_count", inflight_count, 2);
        chk("fl_retire", retire_inc, 0);
        chk("fl_error", error, 0);

        // Free id and duplicate completions.
        next_cycle();
        complete_valid = 4'b0111;
        complete_id[0] = 3'd1;
        complete_id[1] = 3'd7;
        complete_id[2] = 3'd1;
        next_cycle();
        complete_valid = '0;
        @(negedge clk);
        chk("dup_retire", retire_inc, 1);
        chk("dup_error", error, 1);
        chk("dup_count", inflight_count, 1);
        next_cycle();
        @(negedge clk);
        chk("dup_error_pulse", error, 0);

        // Wrap-around, then flush_all blocking an allocation.
        next_cycle();
        complete_valid = 4'b1000;
        complete_id[3] = 3'd0;
        next_cycle();
        complete_valid = '0;
        @(negedge clk);
        chk("p3_count", inflight_count, 0);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            alloc_req  = 1'b1;
            alloc_data = 32'h400 + 32'(i);
        end
        next_cycle();
        alloc_data = 32'h407;
        @(negedge clk);
        chk("wrap_id7", alloc_id, 7);
        chk("wrap_g7", alloc_granted, 1);
        next_cycle();
        alloc_data = 32'h408;
        @(negedge clk);
        chk("wrap_id0", alloc_id, 0);
        chk("wrap_g0", alloc_granted, 1);
        next_cycle();
        flush_all = 1'b1;
        @(negedge clk);
        chk("wrap_id1", alloc_id, 1);
        chk("fa2_granted", alloc_granted, 0);
        chk("fa2_count_before", inflight_count, 7);
        next_cycle();
        flush_all = 1'b0;
        alloc_req = 1'b0;
        @(negedge clk);
        chk("fa2_count", inflight_count, 0);
        chk("fa2_head", alloc_id, 1);
        chk("fa2_read5", read_data, 32'h403);

        // Asynchronous reset with IDs in flight.
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            alloc_req  = 1'b1;
            alloc_data = 32'h500 + 32'(i);
        end
        next_cycle();
        alloc_req      = 1'b0;
        complete_valid = 4'b0001;
        complete_id[0] = 3'd2;
        next_cycle();
        complete_valid = '0;
        @(negedge clk);
        chk("pre_rst_retire", retire_inc, 1);
        chk("pre_rst_count", inflight_count, 2);
        chk("pre_rst_head", alloc_id, 4);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", inflight_count, 0);
        chk("arst_alloc_id", alloc_id, 0);
        chk("arst_retire", retire_inc, 0);
        chk("arst_avail", alloc_available, 1);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_count", inflight_count, 0);
        chk("post_rst_head", alloc_id, 0);

        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
